mandelbrot_iter_unit: RTL

- Parametrised escape-time engine that computes the iteration count of one point c = c_re + i·c_im under z ← z² + c.
- Fixed-point width, fraction bits and iteration-counter width are parameters; the iteration limit is a run-time input.
- Results carry an escaped/bounded flag.
- Sits between the pixel scheduler (which issues start pulses) and the colour mapper (which consumes iterations/escaped when ready).

---
 rtl/mandelbrot_iter_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mandelbrot_iter_unit.sv
// mandelbrot_iter_unit: escape-time engine for one point c under z <- z^2 + c.
// One iteration is evaluated per clock while in ITER. The escape test runs
// on the untruncated squares before every update, so |z| <= 2 whenever a new
// z is formed and no saturation is needed for reasonable c.
// Optional feature: define MANDEL_Z0_EN to add z0_re/z0_im ports that seed
// the initial z (Julia-set rendering); undefined, z always starts at 0.
module mandelbrot_iter_unit #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int ITER_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  c_re,
  input  logic signed [WIDTH-1:0]  c_im,
  input  logic [ITER_W-1:0]        max_iter,
`ifdef MANDEL_Z0_EN
  input  logic signed [WIDTH-1:0]  z0_re,
  input  logic signed [WIDTH-1:0]  z0_im,
`endif
  output logic                     busy,
  output logic                     ready,
  output logic                     escaped,
  output logic [ITER_W-1:0]        iterations
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  // 4.0 expressed at the scale of a full product (2*FRAC fraction bits).
  localparam logic signed [2*WIDTH:0] MAG_LIM =
    {{(2*WIDTH-2*FRAC-2){1'b0}}, 3'b100, {(2*FRAC){1'b0}}};

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] zr_q, zi_q, cr_q, ci_q;
  logic [ITER_W-1:0]       n_q, maxi_q;

  logic signed [2*WIDTH-1:0] zr_x, zi_x;
  logic signed [2*WIDTH-1:0] zr_sq, zi_sq, zrzi;
  logic signed [2*WIDTH:0]   mag, sq_diff, cross2;
  logic signed [WIDTH-1:0]   zr_nxt, zi_nxt;
  logic                      esc_hit, at_limit;
  logic                      load, step, finish;

  // Drop FRAC fraction bits with a floor shift, then keep the low WIDTH bits.
  function automatic logic signed [WIDTH-1:0] scale_trunc(input logic signed [2*WIDTH:0] v);
    return WIDTH'(v >>> FRAC);
  endfunction

  // Squares, cross product, magnitude test and next z for the current point.
  always_comb begin
    zr_x     = {{WIDTH{zr_q[WIDTH-1]}}, zr_q};
    zi_x     = {{WIDTH{zi_q[WIDTH-1]}}, zi_q};
    zr_sq    = zr_x * zr_x;
    zi_sq    = zi_x * zi_x;
    zrzi     = zr_x * zi_x;
    mag      = {zr_sq[2*WIDTH-1], zr_sq} + {zi_sq[2*WIDTH-1], zi_sq};
    sq_diff  = {zr_sq[2*WIDTH-1], zr_sq} - {zi_sq[2*WIDTH-1], zi_sq};
    cross2   = {zrzi, 1'b0};
    zr_nxt   = scale_trunc(sq_diff) + cr_q;
    zi_nxt   = scale_trunc(cross2) + ci_q;
    esc_hit  = (mag > MAG_LIM);
    at_limit = (n_q == maxi_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle action decode; escape has priority over the limit.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        if (esc_hit || at_limit) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration update and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zr_q       <= '0;
      zi_q       <= '0;
      cr_q       <= '0;
      ci_q       <= '0;
      n_q        <= '0;
      maxi_q     <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      escaped    <= 1'b0;
      iterations <= '0;
    end else begin
      if (load) begin
        cr_q    <= c_re;
        ci_q    <= c_im;
        maxi_q  <= max_iter;
`ifdef MANDEL_Z0_EN
        zr_q    <= z0_re;
        zi_q    <= z0_im;
`else
        zr_q    <= '0;
        zi_q    <= '0;
`endif
        n_q     <= '0;
        busy    <= 1'b1;
        ready   <= 1'b0;
        escaped <= 1'b0;
      end
      if (finish) begin
        busy       <= 1'b0;
        ready      <= 1'b1;
        escaped    <= esc_hit;
        iterations <= n_q;
      end
      if (step) begin
        zr_q <= zr_nxt;
        zi_q <= zi_nxt;
        n_q  <= n_q + 1'b1;
      end
    end
  end

endmodule
